// File: rtl/dmem_responder.sv
// dmem_responder
//   Byte-addressed data memory sitting between the load-store queue and the
//   data array. Accepts one load/store per cycle via valid/ready. Aligned
//   stores update the array at the accept edge and produce no response. Loads
//   and misaligned requests of any kind travel a LATENCY-deep shift pipeline
//   into a DEPTH-entry response FIFO. Responses return in accept order.
//   Each accepted response-producing request reserves a FIFO slot through the
//   inflight/fifo_count credit, so a response is never dropped.
//
//   Every byte of the array starts at zero.
//
// Ports
//   clk, rstn        clock, asynchronous active-low reset
//   flush            drop every in-flight and queued response
//   req_valid/ready  request handshake
//   req_we           1 = store, 0 = load
//   req_size         00 byte, 01 half, 10 word, 11 illegal
//   req_unsigned     zero-extend load data
//   req_addr         byte address (ADDR_W bits)
//   req_wdata        right-aligned store data
//   req_tag          request tag (PC), echoed on the response
//   rsp_valid/ready  response handshake
//   rsp_tag          tag of the response at the FIFO head
//   rsp_rdata        extended load data, 0 on error
//   rsp_err          misaligned or illegal access
//   rsp_is_store     error response belongs to a store
module dmem_responder #(
    parameter int ADDR_W  = 10,
    parameter int TAG_W   = 32,
    parameter int LATENCY = 2,
    parameter int DEPTH   = 4
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              flush,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [1:0]        req_size,
    input  logic              req_unsigned,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    input  logic [TAG_W-1:0]  req_tag,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [TAG_W-1:0]  rsp_tag,
    output logic [31:0]       rsp_rdata,
    output logic              rsp_err,
    output logic              rsp_is_store
);

    localparam int CNT_W     = $clog2(DEPTH + 1);
    localparam int PTR_W     = $clog2(DEPTH);
    localparam int MEM_BYTES = 1 << ADDR_W;
    localparam logic [CNT_W:0]   DEPTH_C  = (CNT_W + 1)'(DEPTH);
    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DEPTH - 1);

    typedef struct packed {
        logic [TAG_W-1:0] tag;
        logic [31:0]      data;
        logic             err;
        logic             is_store;
    } entry_t;

    // Data array
    logic [7:0] mem_q [MEM_BYTES];

    // Request decode
    logic [1:0]        off_s;
    logic [ADDR_W-3:0] wbase_s;
    logic              misalign_s;
    logic              accept_s;
    logic              store_wr_s;
    logic              pipe_in_s;
    logic [31:0]       rd_word_s;
    logic [31:0]       rd_shift_s;
    logic [31:0]       ld_ext_s;
    logic [31:0]       ld_data_s;
    logic [3:0]        be_s;
    logic [31:0]       wr_shift_s;
    entry_t            pipe_in_entry_s;

    // Pipeline, FIFO and credit state
    logic [LATENCY-1:0] pipe_vld_q, pipe_vld_d;
    entry_t             pipe_q [LATENCY];
    entry_t             fifo_q [DEPTH];
    entry_t             head_s;
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]   inflight_q, inflight_d;
    logic [CNT_W-1:0]   fifo_count_q, fifo_count_d;
    logic [CNT_W:0]     credit_sum_s;
    logic               push_s;
    logic               pop_s;

    // Clear the array at time 0
    initial begin
        for (int i = 0; i < MEM_BYTES; i++) begin
            mem_q[i] = 8'h00;
        end
    end

    // Credit check: room exists only while pipeline plus FIFO occupancy is below DEPTH
    assign credit_sum_s = {1'b0, inflight_q} + {1'b0, fifo_count_q};
    assign req_ready    = ~flush & (credit_sum_s < DEPTH_C);

    // Alignment check and classification of the accepted request
    always_comb begin
        off_s   = req_addr[1:0];
        wbase_s = req_addr[ADDR_W-1:2];
        case (req_size)
            2'b00:   misalign_s = 1'b0;
            2'b01:   misalign_s = off_s[0];
            2'b10:   misalign_s = (off_s != 2'b00);
            default: misalign_s = 1'b1;
        endcase
        accept_s   = req_valid & req_ready;
        store_wr_s = accept_s & req_we & ~misalign_s;
        // Loads always respond; stores respond only when they fail
        pipe_in_s  = accept_s & (~req_we | misalign_s);
    end

    // Load path: read the containing word, shift the addressed bytes down, extend
    always_comb begin
        rd_word_s  = {mem_q[{wbase_s, 2'd3}], mem_q[{wbase_s, 2'd2}],
                      mem_q[{wbase_s, 2'd1}], mem_q[{wbase_s, 2'd0}]};
        rd_shift_s = rd_word_s >> {off_s, 3'b000};
        case (req_size)
            2'b00: begin
                if (req_unsigned) begin
                    ld_ext_s = {24'h000000, rd_shift_s[7:0]};
                end else begin
                    ld_ext_s = {{24{rd_shift_s[7]}}, rd_shift_s[7:0]};
                end
            end
            2'b01: begin
                if (req_unsigned) begin
                    ld_ext_s = {16'h0000, rd_shift_s[15:0]};
                end else begin
                    ld_ext_s = {{16{rd_shift_s[15]}}, rd_shift_s[15:0]};
                end
            end
            2'b10:   ld_ext_s = rd_shift_s;
            default: ld_ext_s = 32'h00000000;
        endcase
        ld_data_s = misalign_s ? 32'h00000000 : ld_ext_s;

        pipe_in_entry_s.tag      = req_tag;
        pipe_in_entry_s.data     = ld_data_s;
        pipe_in_entry_s.err      = misalign_s;
        pipe_in_entry_s.is_store = req_we;
    end

    // Store path: byte enables and lane-aligned write data
    always_comb begin
        case (req_size)
            2'b00:   be_s = 4'b0001 << off_s;
            2'b01:   be_s = 4'b0011 << off_s;
            2'b10:   be_s = 4'b1111;
            default: be_s = 4'b0000;
        endcase
        wr_shift_s = req_wdata << {off_s, 3'b000};
    end

    // Array write at the accept edge; reset and flush leave contents alone
    always_ff @(posedge clk) begin
        if (store_wr_s) begin
            for (int k = 0; k < 4; k++) begin
                if (be_s[k]) begin
                    mem_q[{wbase_s, 2'(k)}] <= wr_shift_s[8*k +: 8];
                end
            end
        end
    end

    // Next-state for pipeline valids, credit counters and FIFO pointers
    always_comb begin
        push_s = pipe_vld_q[LATENCY-1];
        pop_s  = rsp_valid & rsp_ready;

        pipe_vld_d    = '0;
        pipe_vld_d[0] = pipe_in_s;
        for (int i = 1; i < LATENCY; i++) begin
            pipe_vld_d[i] = pipe_vld_q[i-1];
        end

        case ({pipe_in_s, push_s})
            2'b10:   inflight_d = inflight_q + CNT_W'(1);
            2'b01:   inflight_d = inflight_q - CNT_W'(1);
            default: inflight_d = inflight_q;
        endcase

        case ({push_s, pop_s})
            2'b10:   fifo_count_d = fifo_count_q + CNT_W'(1);
            2'b01:   fifo_count_d = fifo_count_q - CNT_W'(1);
            default: fifo_count_d = fifo_count_q;
        endcase

        // Pointers wrap explicitly so non-power-of-two depths work
        if (push_s) begin
            wr_ptr_d = (wr_ptr_q == PTR_LAST) ? '0 : wr_ptr_q + PTR_W'(1);
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (pop_s) begin
            rd_ptr_d = (rd_ptr_q == PTR_LAST) ? '0 : rd_ptr_q + PTR_W'(1);
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
    end

    // Control state: reset and flush both discard every pending response
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            pipe_vld_q   <= '0;
            inflight_q   <= '0;
            fifo_count_q <= '0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
        end else if (flush) begin
            pipe_vld_q   <= '0;
            inflight_q   <= '0;
            fifo_count_q <= '0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
        end else begin
            pipe_vld_q   <= pipe_vld_d;
            inflight_q   <= inflight_d;
            fifo_count_q <= fifo_count_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
        end
    end

    // Pipeline payload and FIFO storage; qualified by the valids/pointers above
    always_ff @(posedge clk) begin
        pipe_q[0] <= pipe_in_entry_s;
        for (int i = 1; i < LATENCY; i++) begin
            pipe_q[i] <= pipe_q[i-1];
        end
        if (push_s) begin
            fifo_q[wr_ptr_q] <= pipe_q[LATENCY-1];
        end
    end

    // Response outputs come straight from the FIFO head registers, forced to
    // zero when empty so reset and flush present a clean idle response
    always_comb begin
        head_s    = fifo_q[rd_ptr_q];
        rsp_valid = (fifo_count_q != '0);
        if (rsp_valid) begin
            rsp_tag      = head_s.tag;
            rsp_rdata    = head_s.data;
            rsp_err      = head_s.err;
            rsp_is_store = head_s.is_store;
        end else begin
            rsp_tag      = '0;
            rsp_rdata    = 32'h00000000;
            rsp_err      = 1'b0;
            rsp_is_store = 1'b0;
        end
    end

endmodule

// File: tb/tb_dmem_responder.sv
// Directed testbench for dmem_responder (ADDR_W=10, TAG_W=32, LATENCY=2, DEPTH=4).
module tb_dmem_responder;

    logic        clk;
    logic        rstn;
    logic        flush;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [9:0]  req_addr;
    logic [31:0] req_wdata;
    logic [31:0] req_tag;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_tag;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic        rsp_is_store;

    int n_vec;
    int n_miss;

    dmem_responder #(
        .ADDR_W (10),
        .TAG_W  (32),
        .LATENCY(2),
        .DEPTH  (4)
    ) dut (
        .clk         (clk),
        .rstn        (rstn),
        .flush       (flush),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_we      (req_we),
        .req_size    (req_size),
        .req_unsigned(req_unsigned),
        .req_addr    (req_addr),
        .req_wdata   (req_wdata),
        .req_tag     (req_tag),
        .rsp_valid   (rsp_valid),
        .rsp_ready   (rsp_ready),
        .rsp_tag     (rsp_tag),
        .rsp_rdata   (rsp_rdata),
        .rsp_err     (rsp_err),
        .rsp_is_store(rsp_is_store)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_req(input logic we, input logic [1:0] size, input logic uns,
                             input logic [9:0] addr, input logic [31:0] wdata,
                             input logic [31:0] tag);
        req_valid    = 1'b1;
        req_we       = we;
        req_size     = size;
        req_unsigned = uns;
        req_addr     = addr;
        req_wdata    = wdata;
        req_tag      = tag;
    endtask

    task automatic idle_req();
        req_valid    = 1'b0;
        req_we       = 1'b0;
        req_size     = 2'b00;
        req_unsigned = 1'b0;
        req_addr     = 10'h000;
        req_wdata    = 32'h0;
        req_tag      = 32'h0;
    endtask

    task automatic test_reset();
        step();
        step();
        n_vec++; if (rsp_valid !== 1'b0) begin n_miss++; $display("FAIL rst_valid: got %b want 0", rsp_valid); end
        n_vec++; if (rsp_tag !== 32'h0) begin n_miss++; $display("FAIL rst_tag: got %h want 0", rsp_tag); end
        n_vec++; if (rsp_rdata !== 32'h0) begin n_miss++; $display("FAIL rst_rdata: got %h want 0", rsp_rdata); end
        n_vec++; if (rsp_err !== 1'b0) begin n_miss++; $display("FAIL rst_err: got %b want 0", rsp_err); end
        n_vec++; if (rsp_is_store !== 1'b0) begin n_miss++; $display("FAIL rst_is_store: got %b want 0", rsp_is_store); end
        rstn = 1'b1;
        step();
        n_vec++; if (req_ready !== 1'b1) begin n_miss++; $display("FAIL rst_ready: got %b want 1", req_ready); end
    endtask

    task automatic test_store_load();
        logic [1:0]  sz  [5] = '{2'b10, 2'b01, 2'b01, 2'b00, 2'b00};
        logic        un  [5] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
        logic [9:0]  ad  [5] = '{10'h010, 10'h010, 10'h010, 10'h011, 10'h012};
        logic [31:0] ex  [5] = '{32'hDEADBEEF, 32'h0000BEEF, 32'hFFFFBEEF, 32'hFFFFFFBE, 32'h000000AD};
        rsp_ready = 1'b1;
        // Store, then three back-to-back loads; the first load follows the store directly
        drive_req(1'b1, 2'b10, 1'b0, 10'h010, 32'hDEADBEEF, 32'h100);
        n_vec++; if (req_ready !== 1'b1) begin n_miss++; $display("FAIL sl_ready: got %b want 1", req_ready); end
        step();
        drive_req(1'b0, 2'b00, 1'b0, 10'h013, 32'h0, 32'h200);
        step();
        drive_req(1'b0, 2'b00, 1'b1, 10'h013, 32'h0, 32'h204);
        n_vec++; if (rsp_valid !== 1'b0) begin n_miss++; $display("FAIL sl_early0: got %b want 0", rsp_valid); end
        step();
        drive_req(1'b0, 2'b01, 1'b0, 10'h012, 32'h0, 32'h208);
        n_vec++; if (rsp_valid !== 1'b0) begin n_miss++; $display("FAIL sl_early1: got %b want 0", rsp_valid); end
        step();
        idle_req();
        n_vec++; if (rsp_valid !== 1'b1) begin n_miss++; $display("FAIL lb_valid: got %b want 1", rsp_valid); end
        n_vec++; if (rsp_tag !== 32'h200) begin n_miss++; $display("FAIL lb_tag: got %h want 00000200", rsp_tag); end
        n_vec++; if (rsp_rdata !== 32'hFFFFFFDE) begin n_miss++; $display("FAIL lb_data: got %h want ffffffde", rsp_rdata); end
        n_vec++; if (rsp_err !== 1'b0) begin n_miss++; $display("FAIL lb_err: got %b want 0", rsp_err); end
        step();
        n_vec++; if (rsp_valid !== 1'b1) begin n_miss++; $display("FAIL lbu_valid: got %b want 1", rsp_valid); end
        n_vec++; if (rsp_tag !== 32'h204) begin n_miss++; $display("FAIL lbu_tag: got %h want 00000204", rsp_tag); end
        n_vec++; if (rsp_rdata !== 32'h000000DE) begin n_miss++; $display("FAIL lbu_data: got %h want 000000de", rsp_rdata); end
        step();
        n_vec++; if (rsp_valid !== 1'b1) begin n_miss++; $display("FAIL lh_valid: got %b want 1", rsp_valid); end
        n_vec++; if (rsp_tag !== 32'h208) begin n_miss++; $display("FAIL lh_tag: got %h want 00000208", rsp_tag); end
        n_vec++; if (rsp_rdata !== 32'hFFFFDEAD) begin n_miss++; $display("FAIL lh_data: got %h want ffffdead", rsp_rdata); end
        step();
        n_vec++; if (rsp_valid !== 1'b0) begin n_miss++; $display("FAIL sl_drain: got %b want 0", rsp_valid); end
        // Single loads of the stored word with various size/sign settings
        for (int i = 0; i < 5; i++) begin
            drive_req(1'b0, sz[i], un[i], ad[i], 32'h0, 32'h220 + 32'(i));
            step();
            idle_req();
            n_vec++; if (rsp_valid !== 1'b0) begin n_miss++; $display("FAIL ext%0d_early: got %b want 0", i, rsp_valid); end
            step();
            step();
            n_vec++; if (rsp_valid !== 1'b1) begin n_miss++; $display("FAIL ext%0d_valid: got %b want 1", i, rsp_valid); end
            n_vec++; if (rsp_rdata !== ex[i]) begin n_miss++; $display("FAIL ext%0d_data: got %h want %h", i, rsp_rdata, ex[i]); end
            n_vec++; if (rsp_tag !== 32'h220 + 32'(i)) begin n_miss++; $display("FAIL ext%0d_tag: got %h want %h", i, rsp_tag, 32'h220 + 32'(i)); end
        end
        step();
    endtask

    task automatic test_misaligned();
        logic        we  [6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        logic [1:0]  sz  [6] = '{2'b10, 2'b10, 2'b01, 2'b11, 2'b01, 2'b10};
        logic [9:0]  ad  [6] = '{10'h011, 10'h012, 10'h003, 10'h004, 10'h001, 10'h000};
        logic [31:0] ex  [6] = '{32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'hA5A5A5A5};
        logic        er  [6] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        rsp_ready = 1'b1;
        drive_req(1'b1, 2'b10, 1'b0, 10'h000, 32'hA5A5A5A5, 32'h2F0);
        step();
        // Last entry re-reads word 0 to show the misaligned half store left it alone
        for (int i = 0; i < 6; i++) begin
            drive_req(we[i], sz[i], 1'b0, ad[i], 32'h0000FFFF, 32'h300 + 32'(i));
            step();
            idle_req();
            step();
            step();
            n_vec++; if (rsp_valid !== 1'b1) begin n_miss++; $display("FAIL mis%0d_valid: got %b want 1", i, rsp_valid); end
            n_vec++; if (rsp_err !== er[i]) begin n_miss++; $display("FAIL mis%0d_err: got %b want %b", i, rsp_err, er[i]); end
            n_vec++; if (rsp_rdata !== ex[i]) begin n_miss++; $display("FAIL mis%0d_data: got %h want %h", i, rsp_rdata, ex[i]); end
            n_vec++; if (rsp_tag !== 32'h300 + 32'(i)) begin n_miss++; $display("FAIL mis%0d_tag: got %h want %h", i, rsp_tag, 32'h300 + 32'(i)); end
            n_vec++; if (rsp_is_store !== we[i]) begin n_miss++; $display("FAIL mis%0d_is_store: got %b want %b", i, rsp_is_store, we[i]); end
        end
        step();
    endtask

    task automatic test_backpressure();
        logic [31:0] ex [4] = '{32'h000000EF, 32'h000000BE, 32'h000000AD, 32'h000000DE};
        rsp_ready = 1'b0;
        for (int i = 0; i < 6; i++) begin
            drive_req(1'b0, 2'b00, 1'b1, 10'h010 + 10'(i), 32'h0, 32'h400 + 32'(i));
            n_vec++; if (req_ready !== (i < 4)) begin n_miss++; $display("FAIL bp_ready%0d: got %b want %b", i, req_ready, (i < 4)); end
            step();
        end
        idle_req();
        n_vec++; if (req_ready !== 1'b0) begin n_miss++; $display("FAIL bp_full: got %b want 0", req_ready); end
        n_vec++; if (rsp_tag !== 32'h400) begin n_miss++; $display("FAIL bp_head: got %h want 00000400", rsp_tag); end
        step();
        step();
        n_vec++; if (rsp_tag !== 32'h400) begin n_miss++; $display("FAIL bp_hold_tag: got %h want 00000400", rsp_tag); end
        n_vec++; if (rsp_rdata !== 32'h000000EF) begin n_miss++; $display("FAIL bp_hold_data: got %h want 000000ef", rsp_rdata); end
        n_vec++; if (req_ready !== 1'b0) begin n_miss++; $display("FAIL bp_hold_ready: got %b want 0", req_ready); end
        rsp_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            n_vec++; if (rsp_valid !== 1'b1) begin n_miss++; $display("FAIL bp%0d_valid: got %b want 1", k, rsp_valid); end
            n_vec++; if (rsp_tag !== 32'h400 + 32'(k)) begin n_miss++; $display("FAIL bp%0d_tag: got %h want %h", k, rsp_tag, 32'h400 + 32'(k)); end
            n_vec++; if (rsp_rdata !== ex[k]) begin n_miss++; $display("FAIL bp%0d_data: got %h want %h", k, rsp_rdata, ex[k]); end
            step();
            if (k == 0) begin
                n_vec++; if (req_ready !== 1'b1) begin n_miss++; $display("FAIL bp_ready_back: got %b want 1", req_ready); end
            end
        end
        n_vec++; if (rsp_valid !== 1'b0) begin n_miss++; $display("FAIL bp_drain: got %b want 0", rsp_valid); end
    endtask

    task automatic test_flush();
        rsp_ready = 1'b1;
        drive_req(1'b0, 2'b10, 1'b0, 10'h010, 32'h0, 32'h500);
        step();
        drive_req(1'b0, 2'b10, 1'b0, 10'h010, 32'h0, 32'h501);
        n_vec++; if (rsp_valid !== 1'b0) begin n_miss++; $display("FAIL fl_pre0: got %b want 0", rsp_valid); end
        step();
        drive_req(1'b0, 2'b10, 1'b0, 10'h010, 32'h0, 32'h502);
        flush = 1'b1;
        #1;
        n_vec++; if (req_ready !== 1'b0) begin n_miss++; $display("FAIL fl_ready_low: got %b want 0", req_ready); end
        n_vec++; if (rsp_valid !== 1'b0) begin n_miss++; $display("FAIL fl_pre1: got %b want 0", rsp_valid); end
        step();
        flush = 1'b0;
        idle_req();
        #1;
        n_vec++; if (req_ready !== 1'b1) begin n_miss++; $display("FAIL fl_ready_back: got %b want 1", req_ready); end
        for (int i = 0; i < 6; i++) begin
            n_vec++; if (rsp_valid !== 1'b0) begin n_miss++; $display("FAIL fl_quiet%0d: got %b want 0", i, rsp_valid); end
            step();
        end
    endtask

    task automatic test_reset_mid();
        rsp_ready = 1'b1;
        drive_req(1'b1, 2'b10, 1'b0, 10'h020, 32'h11223344, 32'h0);
        step();
        rsp_ready = 1'b0;
        drive_req(1'b0, 2'b10, 1'b0, 10'h020, 32'h0, 32'h600);
        step();
        drive_req(1'b0, 2'b10, 1'b0, 10'h020, 32'h0, 32'h601);
        step();
        idle_req();
        step();
        step();
        n_vec++; if (rsp_valid !== 1'b1) begin n_miss++; $display("FAIL rm_pre_valid: got %b want 1", rsp_valid); end
        n_vec++; if (rsp_rdata !== 32'h11223344) begin n_miss++; $display("FAIL rm_pre_data: got %h want 11223344", rsp_rdata); end
        rstn = 1'b0;
        #1;
        n_vec++; if (rsp_valid !== 1'b0) begin n_miss++; $display("FAIL rm_valid: got %b want 0", rsp_valid); end
        n_vec++; if (rsp_tag !== 32'h0) begin n_miss++; $display("FAIL rm_tag: got %h want 0", rsp_tag); end
        n_vec++; if (rsp_rdata !== 32'h0) begin n_miss++; $display("FAIL rm_rdata: got %h want 0", rsp_rdata); end
        n_vec++; if (rsp_err !== 1'b0) begin n_miss++; $display("FAIL rm_err: got %b want 0", rsp_err); end
        n_vec++; if (rsp_is_store !== 1'b0) begin n_miss++; $display("FAIL rm_is_store: got %b want 0", rsp_is_store); end
        step();
        step();
        rstn = 1'b1;
        rsp_ready = 1'b1;
        #1;
        n_vec++; if (req_ready !== 1'b1) begin n_miss++; $display("FAIL rm_ready: got %b want 1", req_ready); end
        step();
        n_vec++; if (rsp_valid !== 1'b0) begin n_miss++; $display("FAIL rm_empty: got %b want 0", rsp_valid); end
        drive_req(1'b0, 2'b10, 1'b0, 10'h020, 32'h0, 32'h610);
        step();
        idle_req();
        step();
        step();
        n_vec++; if (rsp_valid !== 1'b1) begin n_miss++; $display("FAIL rm_ld_valid: got %b want 1", rsp_valid); end
        n_vec++; if (rsp_rdata !== 32'h11223344) begin n_miss++; $display("FAIL rm_ld_data: got %h want 11223344", rsp_rdata); end
        n_vec++; if (rsp_tag !== 32'h610) begin n_miss++; $display("FAIL rm_ld_tag: got %h want 00000610", rsp_tag); end
        step();
    endtask

    task automatic test_top_addr();
        rsp_ready = 1'b1;
        drive_req(1'b1, 2'b00, 1'b0, 10'h3FF, 32'h00000055, 32'h0);
        step();
        drive_req(1'b0, 2'b00, 1'b0, 10'h3FF, 32'h0, 32'h700);
        step();
        idle_req();
        step();
        step();
        n_vec++; if (rsp_valid !== 1'b1) begin n_miss++; $display("FAIL top_valid: got %b want 1", rsp_valid); end
        n_vec++; if (rsp_rdata !== 32'h00000055) begin n_miss++; $display("FAIL top_data: got %h want 00000055", rsp_rdata); end
        n_vec++; if (rsp_err !== 1'b0) begin n_miss++; $display("FAIL top_err: got %b want 0", rsp_err); end
        n_vec++; if (rsp_tag !== 32'h700) begin n_miss++; $display("FAIL top_tag: got %h want 00000700", rsp_tag); end
        step();
    endtask

    initial begin
        n_vec     = 0;
        n_miss    = 0;
        rstn      = 1'b0;
        flush     = 1'b0;
        rsp_ready = 1'b1;
        idle_req();
        test_reset();
        test_store_load();
        test_misaligned();
        test_backpressure();
        test_flush();
        test_reset_mid();
        test_top_addr();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
